// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle main control FSM.
// Holds the state encoding, mux select codes, opcodes and the DECODE dispatch.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_MULEX    = 4'd10,
    S_MULWB_LO = 4'd11,
    S_MULWB_HI = 4'd12
  } state_t;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] OP_DP       = 2'b00;
  localparam logic [1:0] OP_MEM      = 2'b01;
  localparam logic [1:0] OP_BR       = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       wb_hi;
    logic       mul_start;
    logic       illegal;
  } ctrl_t;

  // Successor of DECODE; returning S_FETCH from here means the opcode is illegal.
  function automatic state_t decode_next(input logic [1:0] op,
                                         input logic       funct_i,
                                         input logic       is_mul,
                                         input logic       is_long,
                                         input logic       long_en);
    state_t nx;
    nx = S_FETCH;
    case (op)
      OP_MEM: nx = S_MEMADR;
      OP_BR:  nx = S_BRANCH;
      OP_DP: begin
        if (is_mul) nx = (!is_long || long_en) ? S_MULEX : S_FETCH;
        else        nx = funct_i ? S_EXECUTEI : S_EXECUTER;
      end
      default: nx = S_FETCH;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/mc_latcnt.sv
// Loadable down-counter that times the iterative multiply phase.
// Load wins over enable; the count stops at zero.
module mc_latcnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && (cnt != '0))  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mc_mainfsm_ext.sv
// Multicycle ARM main control FSM with memory wait states, an iterative
// multiply phase and a two-cycle write-back for 64-bit long multiplies.
import mc_pkg::*;

module mc_mainfsm_ext #(
  parameter int MUL_CYCLES = 4,
  parameter int LONG_MUL   = 1,
  parameter int MEM_WAIT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       is_mul,
  input  logic       is_long,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       wb_hi,
  output logic       mul_start,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  state_t        state;
  state_t        state_nx;
  state_t        dec_nx;
  ctrl_t         ctrl;
  logic          mem_ok;
  logic          long_en;
  logic          cnt_load;
  logic          cnt_en;
  logic          cnt_zero;
  logic [CW-1:0] cnt;
  logic          unused_funct;

  assign mem_ok       = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign long_en      = (LONG_MUL != 0);
  assign dec_nx       = decode_next(op, funct[5], is_mul, is_long, long_en);
  assign unused_funct = ^funct[4:1];

  // The counter is loaded on the DECODE->MULEX edge so MULEX starts at MUL_CYCLES-1.
  assign cnt_load = (state == S_DECODE) && (dec_nx == S_MULEX);
  assign cnt_en   = (state == S_MULEX);

  mc_latcnt #(.W(CW)) u_latcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (CW'(MUL_CYCLES - 1)),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:    state_nx = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE:   state_nx = dec_nx;
      S_MEMADR:   state_nx = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_nx = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWR:    state_nx = mem_ok ? S_FETCH : S_MEMWR;
      S_EXECUTER: state_nx = S_ALUWB;
      S_EXECUTEI: state_nx = S_ALUWB;
      S_ALUWB:    state_nx = S_FETCH;
      S_BRANCH:   state_nx = S_FETCH;
      S_MULEX:    state_nx = cnt_zero ? S_MULWB_LO : S_MULEX;
      S_MULWB_LO: state_nx = (is_long && long_en) ? S_MULWB_HI : S_FETCH;
      S_MULWB_HI: state_nx = S_FETCH;
      default:    state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ok;
        ctrl.next_pc    = mem_ok;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.illegal    = (dec_nx == S_FETCH);
      end
      S_MEMADR:   ctrl.alu_src_b = SRCB_IMM;
      S_MEMRD:    ctrl.adr_src   = 1'b1;
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      S_EXECUTER: ctrl.alu_op = 1'b1;
      S_EXECUTEI: begin
        ctrl.alu_op    = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ALUWB:    ctrl.reg_w = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_ALUOUT;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.branch     = 1'b1;
      end
      S_MULEX: begin
        ctrl.alu_op = 1'b1;
        // The count only holds MUL_CYCLES-1 on the entry cycle.
        ctrl.mul_start = (cnt == CW'(MUL_CYCLES - 1));
      end
      S_MULWB_LO: ctrl.reg_w = 1'b1;
      S_MULWB_HI: begin
        ctrl.reg_w = 1'b1;
        ctrl.wb_hi = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // While reset is held the state already reads FETCH; only the strobes need masking.
    if (!reset) begin
      ctrl.ir_write  = 1'b0;
      ctrl.next_pc   = 1'b0;
      ctrl.reg_w     = 1'b0;
      ctrl.mem_w     = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.alu_op    = 1'b0;
      ctrl.wb_hi     = 1'b0;
      ctrl.mul_start = 1'b0;
      ctrl.illegal   = 1'b0;
    end
  end

  assign IRWrite   = ctrl.ir_write;
  assign NextPC    = ctrl.next_pc;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;
  assign ALUOp     = ctrl.alu_op;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign wb_hi     = ctrl.wb_hi;
  assign mul_start = ctrl.mul_start;
  assign illegal   = ctrl.illegal;
  assign state_o   = state;

endmodule

// File: tb/tb_mc_mainfsm_ext.sv
// Bench for mc_mainfsm_ext: two configurations, per-instruction cycle plans
// built from the instruction timing rules, compared on every cycle.
module tb_mc_mainfsm_ext;

  localparam int EW = 20;
  localparam int K_BR = 0, K_DPR = 1, K_DPI = 2, K_LDR = 3, K_STR = 4,
                 K_MUL = 5, K_LMUL = 6, K_ILL = 7;

  // clock / reset
  logic clk = 1'b0;
  logic reset_a, reset_b;
  always #5 clk = ~clk;

  logic [1:0] op;
  logic [5:0] funct;
  logic       is_mul, is_long, mem_ready;

  logic       a_irw, a_npc, a_regw, a_memw, a_br, a_aluop, a_adr, a_hi, a_ms, a_ill;
  logic [1:0] a_srca, a_srcb, a_rsrc;
  logic [3:0] a_state;
  logic       b_irw, b_npc, b_regw, b_memw, b_br, b_aluop, b_adr, b_hi, b_ms, b_ill;
  logic [1:0] b_srca, b_srcb, b_rsrc;
  logic [3:0] b_state;

  mc_mainfsm_ext #(.MUL_CYCLES(4), .LONG_MUL(1), .MEM_WAIT(1)) dut_a (
    .clk(clk), .reset(reset_a), .op(op), .funct(funct), .is_mul(is_mul),
    .is_long(is_long), .mem_ready(mem_ready), .IRWrite(a_irw), .NextPC(a_npc),
    .RegW(a_regw), .MemW(a_memw), .Branch(a_br), .ALUOp(a_aluop), .AdrSrc(a_adr),
    .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ResultSrc(a_rsrc), .wb_hi(a_hi),
    .mul_start(a_ms), .illegal(a_ill), .state_o(a_state)
  );

  mc_mainfsm_ext #(.MUL_CYCLES(1), .LONG_MUL(0), .MEM_WAIT(0)) dut_b (
    .clk(clk), .reset(reset_b), .op(op), .funct(funct), .is_mul(is_mul),
    .is_long(is_long), .mem_ready(mem_ready), .IRWrite(b_irw), .NextPC(b_npc),
    .RegW(b_regw), .MemW(b_memw), .Branch(b_br), .ALUOp(b_aluop), .AdrSrc(b_adr),
    .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ResultSrc(b_rsrc), .wb_hi(b_hi),
    .mul_start(b_ms), .illegal(b_ill), .state_o(b_state)
  );

  logic [EW-1:0] act_a, act_b, act;
  logic          sel;
  assign act_a = {a_state, a_irw, a_npc, a_regw, a_memw, a_br, a_aluop, a_adr,
                  a_srca, a_srcb, a_rsrc, a_hi, a_ms, a_ill};
  assign act_b = {b_state, b_irw, b_npc, b_regw, b_memw, b_br, b_aluop, b_adr,
                  b_srca, b_srcb, b_rsrc, b_hi, b_ms, b_ill};
  assign act   = sel ? act_b : act_a;

  // model configuration of the instance under test
  int cur_mc, cur_lm, cur_mw;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_regw, n_memw, n_ms, n_ill, n_br, n_irw;

  logic [EW-1:0] exp_q[$];
  bit            pl_mr[$];
  logic [EW-1:0] pl_exp[$];

  function automatic logic [EW-1:0] vec(int st, bit irw, bit npc, bit regw, bit memw,
                                        bit br, bit aluop, bit adr, logic [1:0] a,
                                        logic [1:0] b, logic [1:0] r, bit hi, bit ms, bit ill);
    return {4'(st), irw, npc, regw, memw, br, aluop, adr, a, b, r, hi, ms, ill};
  endfunction

  function automatic logic [EW-1:0] fetch_v(bit ir);
    return vec(0, ir, ir, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0);
  endfunction

  function automatic logic [EW-1:0] decode_v(bit ill);
    return vec(1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0, 0, ill);
  endfunction

  task automatic chk(string name, int actual, int required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // scoreboard: one expected output vector per cycle
  always @(negedge clk) begin
    logic [EW-1:0] e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL vec cyc=%0d actual=%05h required=%05h", cyc, act, e);
      end
      n_irw  += int'(act[15]);
      n_regw += int'(act[13]);
      n_memw += int'(act[12]);
      n_br   += int'(act[11]);
      n_ms   += int'(act[1]);
      n_ill  += int'(act[0]);
    end
  end

  // model: per-instruction cycle plan
  task automatic p(bit mr, logic [EW-1:0] e);
    pl_mr.push_back(mr);
    pl_exp.push_back(e);
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // A waited phase: with wait states honoured each low cycle repeats the phase;
  // otherwise a low mem_ready is simply ignored.
  task automatic plan_waited(logic [EW-1:0] wait_v, logic [EW-1:0] done_v, int w);
    if (cur_mw != 0) begin
      repeat (w) p(1'b0, wait_v);
      p(1'b1, done_v);
    end else begin
      p((w > 0) ? 1'b0 : 1'b1, done_v);
    end
  endtask

  task automatic plan_instr(int kind, int fw, int w);
    logic [EW-1:0] mv;
    plan_waited(fetch_v(0), fetch_v(1), fw);
    case (kind)
      K_BR: begin
        p(rnd(), decode_v(0));
        p(rnd(), vec(9, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b01, 2'b10, 0, 0, 0));
      end
      K_DPR, K_DPI: begin
        p(rnd(), decode_v(0));
        if (kind == K_DPR) p(rnd(), vec(6, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        else               p(rnd(), vec(7, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0));
        p(rnd(), vec(8, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
      end
      K_LDR: begin
        p(rnd(), decode_v(0));
        p(rnd(), vec(2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0));
        mv = vec(3, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        plan_waited(mv, mv, w);
        p(rnd(), vec(4, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0, 0, 0));
      end
      K_STR: begin
        p(rnd(), decode_v(0));
        p(rnd(), vec(2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0));
        mv = vec(5, 0, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        plan_waited(mv, mv, w);
      end
      K_MUL, K_LMUL: begin
        if (kind == K_LMUL && cur_lm == 0) begin
          p(rnd(), decode_v(1));
        end else begin
          p(rnd(), decode_v(0));
          for (int i = 0; i < cur_mc; i++)
            p(rnd(), vec(10, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, (i == 0), 0));
          p(rnd(), vec(11, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
          if (kind == K_LMUL)
            p(rnd(), vec(12, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0));
        end
      end
      default: p(rnd(), decode_v(1));
    endcase
  endtask

  // driver tasks
  task automatic set_fields(int kind);
    is_mul = 1'b0; is_long = 1'b0;
    case (kind)
      K_BR:   begin op = 2'b10; funct = 6'b101000; end
      K_DPR:  begin op = 2'b00; funct = 6'b001000; end
      K_DPI:  begin op = 2'b00; funct = 6'b101000; end
      K_LDR:  begin op = 2'b01; funct = 6'b011001; end
      K_STR:  begin op = 2'b01; funct = 6'b011000; end
      K_MUL:  begin op = 2'b00; funct = 6'b100000; is_mul = 1'b1; end
      K_LMUL: begin op = 2'b00; funct = 6'b101000; is_mul = 1'b1; is_long = 1'b1; end
      default: begin op = 2'b11; funct = 6'b000000; end
    endcase
  endtask

  task automatic run_plan(int limit);
    int n = 0;
    while (pl_mr.size() > 0 && n < limit) begin
      mem_ready = pl_mr.pop_front();
      exp_q.push_back(pl_exp.pop_front());
      @(posedge clk); #1;
      n++;
    end
    pl_mr.delete();
    pl_exp.delete();
  endtask

  task automatic instr(string name, int kind, int fw, int w, int exp_len);
    set_fields(kind);
    plan_instr(kind, fw, w);
    chk({name, "_len"}, pl_mr.size(), exp_len);
    n_regw = 0; n_memw = 0; n_ms = 0; n_ill = 0; n_br = 0; n_irw = 0;
    run_plan(1000);
  endtask

  task automatic reset_cycles(int n);
    repeat (n) p(1'b1, fetch_v(0));
    run_plan(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a = 1'b0; reset_b = 1'b0; sel = 1'b0;
    op = 2'b00; funct = 6'd0; is_mul = 1'b0; is_long = 1'b0; mem_ready = 1'b1;
    cur_mc = 4; cur_lm = 1; cur_mw = 1;
    @(posedge clk); #1;
    chk("rst_state", int'(a_state), 0);
    chk("rst_irwrite", int'(a_irw), 0);
    reset_cycles(2);
    reset_a = 1'b1;

    // configuration A: MUL_CYCLES=4, LONG_MUL=1, MEM_WAIT=1
    instr("br", K_BR, 0, 0, 3);
    chk("br_pulses", n_br, 1);
    instr("dpr", K_DPR, 0, 0, 4);
    instr("dpi", K_DPI, 1, 0, 5);
    instr("ldr_w2", K_LDR, 0, 2, 7);
    chk("ldr_regw", n_regw, 1);
    instr("str_w3", K_STR, 0, 3, 7);
    chk("str_memw", n_memw, 4);
    instr("ldr", K_LDR, 0, 0, 5);
    instr("str", K_STR, 2, 0, 6);
    chk("str_irw", n_irw, 1);
    instr("mul", K_MUL, 0, 0, 7);
    chk("mul_start", n_ms, 1);
    chk("mul_regw", n_regw, 1);
    instr("mul_b2b", K_MUL, 0, 0, 7);
    chk("mul_b2b_start", n_ms, 1);
    instr("umull", K_LMUL, 0, 0, 8);
    chk("umull_regw", n_regw, 2);
    instr("ill", K_ILL, 0, 0, 2);
    chk("ill_pulse", n_ill, 1);
    instr("br2", K_BR, 0, 0, 3);

    // reset in the middle of MULEX
    set_fields(K_MUL);
    plan_instr(K_MUL, 0, 0);
    run_plan(4);
    reset_a = 1'b0;
    #1;
    chk("midrst_state", int'(a_state), 0);
    chk("midrst_strobes", int'({a_irw, a_npc, a_regw, a_memw, a_br, a_aluop, a_hi, a_ms, a_ill}), 0);
    chk("midrst_selects", int'({a_adr, a_srca, a_srcb, a_rsrc}), 7'b0011010);
    @(posedge clk); #1;
    reset_cycles(1);
    reset_a = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("post_rst_irwrite", int'(a_irw), 1);
    instr("mul_after_rst", K_MUL, 0, 0, 7);
    chk("mul_after_rst_start", n_ms, 1);

    // configuration B: MUL_CYCLES=1, LONG_MUL=0, MEM_WAIT=0
    reset_a = 1'b0;
    sel = 1'b1;
    cur_mc = 1; cur_lm = 0; cur_mw = 0;
    reset_cycles(1);
    reset_b = 1'b1;
    instr("b_mul", K_MUL, 0, 0, 4);
    chk("b_mul_start", n_ms, 1);
    instr("b_mul_b2b", K_MUL, 0, 0, 4);
    chk("b_mul_b2b_start", n_ms, 1);
    instr("b_umull", K_LMUL, 0, 0, 2);
    chk("b_umull_ill", n_ill, 1);
    chk("b_umull_regw", n_regw, 0);
    instr("b_ldr_nowait", K_LDR, 1, 2, 5);
    instr("b_str_nowait", K_STR, 0, 3, 4);
    chk("b_str_memw", n_memw, 1);
    instr("b_dpi", K_DPI, 0, 0, 4);
    instr("b_ill", K_ILL, 0, 0, 2);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_mainfsm_ext.md
# mc_mainfsm_ext

Parametrised successor to the multicycle ARM main control FSM. It sequences fetch, decode, memory, data-processing, branch and multiply instructions. It adds memory wait-state handshaking, a fixed-latency iterative multiply phase, and a two-cycle write-back for 64-bit long multiplies (UMULL/SMULL). It sits inside the decoder, between the instruction register fields and the datapath mux/strobe controls. Conditional gating of RegW/MemW/Branch stays in condition logic downstream.

## Interface
- MUL_CYCLES, 4: multiply execute latency in cycles, legal range 1..15.
- LONG_MUL, 1: 1 enables the 64-bit two-write-back path; 0 treats long multiplies as illegal.
- MEM_WAIT, 1: 1 honours mem_ready; 0 treats mem_ready as constantly 1.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  2  Instr[27:26].
- funct  in  6  Instr[25:20].
- is_mul  in  1  decoder flag: Instr[7:4]==4'b1001 with op==00.
- is_long  in  1  decoder flag: UMULL/SMULL.
- mem_ready  in  1  memory completes the current access this cycle.
- IRWrite, NextPC, RegW, MemW, Branch, ALUOp  out  1 each  datapath strobes.
- AdrSrc  out  1  address mux select.
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  mux selects.
- wb_hi  out  1  1 selects the high product word and the RdHi register address.
- mul_start  out  1  one-cycle pulse that starts the multiplier.
- illegal  out  1  one-cycle pulse on an unimplemented opcode.
- state_o  out  4  current state encoding, for debug.

## Operation
- Outputs are a Moore decode of the state, except the strobes gated by mem_ready. Unlisted selects are 00; unlisted strobes are 0.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=mem_ready. Stays until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state by priority:
  - op==01 -> MEMADR.
  - op==10 -> BRANCH.
  - op==00 & is_mul & (~is_long | LONG_MUL) -> MULEX.
  - op==00 & is_mul (long, with LONG_MUL=0) -> FETCH, illegal=1.
  - op==00 & funct[5] -> EXECUTEI.
  - op==00 -> EXECUTER.
  - op==11 -> FETCH, illegal=1.
- MEMADR: ALUSrcB=01. funct[0]=1 -> MEMRD; otherwise -> MEMWR.
- MEMRD: AdrSrc=1. Stays until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegW=1 -> FETCH.
- MEMWR: AdrSrc=1. MemW=1 is held every cycle until mem_ready, then the FSM goes to FETCH.
- EXECUTER: ALUOp=1 -> ALUWB.
- EXECUTEI: ALUOp=1, ALUSrcB=01 -> ALUWB.
- ALUWB: RegW=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.
- MULEX: ALUOp=1.
  - On the entry cycle, mul_start=1 and cnt loads MUL_CYCLES-1.
  - cnt decrements each cycle; the FSM leaves when cnt==0.
  - MUL_CYCLES=1 gives exactly one MULEX cycle.
  - Exit -> MULWB_LO.
- MULWB_LO: RegW=1, wb_hi=0. is_long & LONG_MUL -> MULWB_HI; otherwise -> FETCH.
- MULWB_HI: RegW=1, wb_hi=1 -> FETCH.
- op, funct, is_mul and is_long come from the held instruction register, so they are stable from DECODE until the next FETCH. The FSM does not latch them.

## Timing
- Reset asserted (low), including mid-instruction:
  - state=FETCH and cnt=0 immediately.
  - All strobes (IRWrite, NextPC, RegW, MemW, Branch, mul_start, illegal, wb_hi) are forced to 0.
  - Selects hold their FETCH values.
- First fetch completes on the first rising edge after deassertion that sees mem_ready=1.
- Cycles per instruction with zero wait states:
  - branch 3, ALU 4, STR 4, LDR 5.
  - MUL 3+MUL_CYCLES.
  - UMULL/SMULL 4+MUL_CYCLES.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. No strobe duplicates across a wait: IRWrite and NextPC pulse once; MemW is level and the write commits on the mem_ready cycle.
- mul_start is high for exactly one cycle per multiply, including back-to-back multiplies.
- RegW pulses twice for a long multiply, on consecutive cycles, with wb_hi 0 then 1.

## Structure
- Shared package mc_pkg holds:
  - the state enum (13 states, 4-bit encoding: FETCH=0 … MULWB_HI=12);
  - constants for ALUSrcA/ALUSrcB/ResultSrc codes;
  - op codes OP_DP=00, OP_MEM=01, OP_BR=10.
- One natural sub-module: mc_latcnt, a loadable down-counter of width $clog2(MUL_CYCLES+1) with load, enable and zero flag. MULEX exit uses that zero flag.

## Test plan
- Reset low mid-MULEX -> state_o=0 and all strobes 0 at once. After release with mem_ready=1, IRWrite=1 on the first cycle.
- LDR with mem_ready low for 2 cycles in MEMRD -> 7-cycle instruction, exactly one RegW pulse with ResultSrc=01.
- STR with MEM_WAIT=1 and mem_ready low for 3 cycles -> MemW high for 4 consecutive cycles, then FETCH.
- MUL with MUL_CYCLES=4 -> mul_start pulse on cycle 3, 4 MULEX cycles, one RegW with wb_hi=0, 7 cycles total. Repeat with MUL_CYCLES=1 -> 4 cycles total.
- UMULL with LONG_MUL=1 -> RegW on two consecutive cycles with wb_hi 0 then 1. Same instruction with LONG_MUL=0 -> illegal pulse in DECODE, no RegW, return to FETCH.
- op=11 -> illegal=1 for one cycle, then FETCH. Branch -> Branch=1 in cycle 3, ALUSrcA=10.
